fetch_unit: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the pipelined controller.
- Owns PC_F and issues word requests to instruction memory over a valid/ready request channel with a response-valid return; at most one request is outstanding.
- Delivers instr_D/pc_D to decode; the decode-stage fields are fixed slices of instr_D.
- Honours Stall_F, Stall_D and Flush_D from the hazard unit and the PCSrc_E/PCTarget_E redirect from execute.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/if_id_reg.sv | 50 +++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch/decode constants: widths, reset PC, bubble encoding,
// fetch FSM state type and RV32 instruction field positions.
package riscv_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_BUBBLE       = 32'h0000_0000;

  // Legacy state codes kept as constants so existing encodings stay stable.
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD
  } fetch_state_t;

  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned OP_W     = 7;
  localparam int unsigned RD_LSB   = 7;
  localparam int unsigned F3_LSB   = 12;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned RS1_LSB  = 15;
  localparam int unsigned RS2_LSB  = 20;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned F7B5_BIT = 30;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush > stall > load (instruction or bubble).
module if_id_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);
  import riscv_pkg::NOP_BUBBLE;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pcplus4_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      instr_q   <= NOP_BUBBLE;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (!stall_i) begin
      if (load_valid_i) begin
        instr_q   <= instr_i;
        pc_q      <= pc_i;
        pcplus4_q <= pc_i + XLEN'(4);
        valid_q   <= 1'b1;
      end else begin
        instr_q   <= NOP_BUBBLE;
        pc_q      <= '0;
        pcplus4_q <= '0;
        valid_q   <= 1'b0;
      end
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC_F, runs a single-outstanding request/response
// handshake with instruction memory and feeds the IF/ID register.
module fetch_unit #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            Stall_F,
  input  logic            Stall_D,
  input  logic            Flush_D,
  input  logic            PCSrc_E,
  input  logic [XLEN-1:0] PCTarget_E,
  output logic [31:0]     instr_D,
  output logic [XLEN-1:0] pc_D,
  output logic [XLEN-1:0] pcplus4_D,
  output logic            valid_D,
  output logic [6:0]      op_D,
  output logic [2:0]      funct3_D,
  output logic            funct7b5_D,
  output logic [4:0]      rs1_D,
  output logic [4:0]      rs2_D,
  output logic [4:0]      rd_D,
  output logic            fetch_busy
);
  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  logic [31:0]     hold_q, hold_d;

  logic            rsp_live;
  logic            avail;
  logic            handoff;
  logic [31:0]     avail_instr;
  logic [XLEN-1:0] target;
  logic            unused_tgt_lsbs;

  assign target          = {PCTarget_E[XLEN-1:2], 2'b00};
  assign unused_tgt_lsbs = ^PCTarget_E[1:0];

  assign rsp_live    = (state_q == WAIT) && imem_rsp_valid && !discard_q;
  assign avail       = rsp_live || (state_q == HOLD);
  assign avail_instr = (state_q == HOLD) ? hold_q : imem_rsp_data;
  // A redirect suppresses hand-off so no wrong-path word reaches decode.
  assign handoff     = avail && !Stall_D && !Stall_F && !PCSrc_E;

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign fetch_busy     = !avail;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    hold_d    = hold_q;

    case (state_q)
      REQ: begin
        if (imem_req_ready) begin
          state_d   = WAIT;
          discard_d = PCSrc_E;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          discard_d = 1'b0;
          if (discard_q || PCSrc_E || handoff) begin
            state_d = REQ;
          end else begin
            hold_d  = imem_rsp_data;
            state_d = HOLD;
          end
        end else if (PCSrc_E) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (PCSrc_E || handoff) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    if (PCSrc_E)      pc_d = target;
    else if (handoff) pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      hold_q    <= hold_d;
    end
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (Flush_D),
    .stall_i      (Stall_D),
    .load_valid_i (handoff),
    .instr_i      (avail_instr),
    .pc_i         (pc_q),
    .instr_o      (instr_D),
    .pc_o         (pc_D),
    .pcplus4_o    (pcplus4_D),
    .valid_o      (valid_D)
  );

  assign op_D       = instr_D[OP_LSB +: OP_W];
  assign funct3_D   = instr_D[F3_LSB +: F3_W];
  assign funct7b5_D = instr_D[F7B5_BIT];
  assign rs1_D      = instr_D[RS1_LSB +: REG_W];
  assign rs2_D      = instr_D[RS2_LSB +: REG_W];
  assign rd_D       = instr_D[RD_LSB +: REG_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model of the fetch stream plus
// a behavioural instruction memory with random ready/latency.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        Stall_F, Stall_D, Flush_D, PCSrc_E;
  logic [31:0] PCTarget_E;
  logic [31:0] instr_D, pc_D, pcplus4_D;
  logic        valid_D;
  logic [6:0]  op_D;
  logic [2:0]  funct3_D;
  logic        funct7b5_D;
  logic [4:0]  rs1_D, rs2_D, rd_D;
  logic        fetch_busy;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .Stall_F        (Stall_F),
    .Stall_D        (Stall_D),
    .Flush_D        (Flush_D),
    .PCSrc_E        (PCSrc_E),
    .PCTarget_E     (PCTarget_E),
    .instr_D        (instr_D),
    .pc_D           (pc_D),
    .pcplus4_D      (pcplus4_D),
    .valid_D        (valid_D),
    .op_D           (op_D),
    .funct3_D       (funct3_D),
    .funct7b5_D     (funct7b5_D),
    .rs1_D          (rs1_D),
    .rs2_D          (rs2_D),
    .rd_D           (rd_D),
    .fetch_busy     (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk, n_pass, n_fail;

  // memory model
  logic [31:0] imem [256];
  int          rdy_pct, lat_lo, lat_hi;
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;
  int unsigned n_hs;

  // reference model of the fetch stream
  logic [31:0] m_pc;
  logic        outst, live, have;
  logic        d_v;
  logic [31:0] d_pc, d_p4, d_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return imem[a[9:2]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory, check pre-edge outputs, advance, check D stage.
  task automatic cycle();
    logic        rsp_now, hs_dut, m_hs, exp_rv, avail_m, hand;
    logic [31:0] hs_addr;
    imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
    imem_rsp_valid = pend && (cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr) : $urandom();
    #1;
    rsp_now = imem_rsp_valid;
    hs_dut  = imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
    exp_rv  = !outst && !have;
    m_hs    = exp_rv && imem_req_ready;
    avail_m = have || (outst && live && rsp_now);
    hand    = avail_m && !Stall_D && !Stall_F && !PCSrc_E;
    if (!reset) begin
      if (hs_dut) n_hs++;
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, !avail_m});
    end

    @(posedge clk);
    #1;

    if (reset || rsp_now) pend = 1'b0;
    else if (hs_dut) begin
      pend      = 1'b1;
      pend_addr = hs_addr;
      cnt       = $urandom_range(lat_hi, lat_lo);
    end else if (pend && cnt != 0) cnt--;

    if (reset) begin
      m_pc = 32'h0; outst = 0; live = 0; have = 0;
      d_v = 0; d_pc = 0; d_p4 = 0; d_in = 0;
    end else begin
      if (Flush_D) begin
        d_v = 0; d_pc = 0; d_p4 = 0; d_in = 0;
      end else if (!Stall_D) begin
        if (hand) begin
          d_v = 1; d_pc = m_pc; d_p4 = m_pc + 32'd4; d_in = mem_word(m_pc);
        end else begin
          d_v = 0; d_pc = 0; d_p4 = 0; d_in = 0;
        end
      end
      if (rsp_now && outst) begin
        outst = 0;
        if (live) have = 1;
      end
      if (hand) begin
        have = 0;
        m_pc = m_pc + 32'd4;
      end
      if (PCSrc_E) begin
        m_pc = PCTarget_E & 32'hFFFF_FFFC;
        have = 0;
        live = 0;
      end
      if (m_hs) begin
        outst = 1;
        live  = !PCSrc_E;
      end
    end

    chk("valid_D", {31'b0, valid_D}, {31'b0, d_v});
    chk("instr_D", instr_D, d_in);
    chk("pc_D", pc_D, d_pc);
    chk("pcplus4_D", pcplus4_D, d_p4);
    chk("op_D", {25'b0, op_D}, d_in & 32'h7f);
    chk("rd_D", {27'b0, rd_D}, (d_in >> 7) & 32'h1f);
    chk("funct3_D", {29'b0, funct3_D}, (d_in >> 12) & 32'h7);
    chk("rs1_D", {27'b0, rs1_D}, (d_in >> 15) & 32'h1f);
    chk("rs2_D", {27'b0, rs2_D}, (d_in >> 20) & 32'h1f);
    chk("funct7b5_D", {31'b0, funct7b5_D}, (d_in >> 30) & 32'h1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned hs0;
    n_chk = 0; n_pass = 0; n_fail = 0; n_hs = 0;
    for (int i = 0; i < 256; i++) imem[i] = $urandom();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h0010_0113;
    pend = 0; pend_addr = 0; cnt = 0;
    rdy_pct = 100; lat_lo = 0; lat_hi = 0;
    m_pc = 0; outst = 0; live = 0; have = 0;
    d_v = 0; d_pc = 0; d_p4 = 0; d_in = 0;
    reset = 1; Stall_F = 0; Stall_D = 0; Flush_D = 0; PCSrc_E = 0; PCTarget_E = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;

    @(negedge clk);
    cycle(); cycle();
    reset = 0;
    chk("rst_valid_D", {31'b0, valid_D}, 32'd0);
    chk("rst_instr_D", instr_D, 32'd0);
    chk("rst_pc_D", pc_D, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'd0);

    // zero-wait memory, first two instructions
    cycle(); cycle();
    chk("first_pc", pc_D, 32'h0);
    chk("first_valid", {31'b0, valid_D}, 32'd1);
    chk("first_instr", instr_D, 32'h0050_0093);
    chk("first_rd", {27'b0, rd_D}, 32'd1);
    chk("first_rs1", {27'b0, rs1_D}, 32'd0);
    cycle(); cycle();
    chk("second_pc", pc_D, 32'h4);
    chk("second_instr", instr_D, 32'h0010_0113);
    chk("second_rd", {27'b0, rd_D}, 32'd2);

    // memory not ready for three cycles at PC 0x8
    hs0 = n_hs;
    rdy_pct = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("notready_addr", imem_req_addr, 32'h8);
      chk("notready_valid", {31'b0, valid_D}, 32'd0);
    end
    rdy_pct = 100;

    // response while Stall_D high for two cycles
    Stall_D = 1;
    cycle();
    cycle();
    chk("hold_busy", {31'b0, fetch_busy}, 32'd0);
    chk("hold_req", {31'b0, imem_req_valid}, 32'd0);
    cycle();
    chk("hold_busy2", {31'b0, fetch_busy}, 32'd0);
    chk("hold_valid", {31'b0, valid_D}, 32'd0);
    Stall_D = 0;
    cycle();
    chk("release_pc", pc_D, 32'h8);
    chk("release_instr", instr_D, mem_word(32'h8));
    chk("single_hs", n_hs - hs0, 32'd1);
    chk("release_next_addr", imem_req_addr, 32'hC);

    // redirect while waiting on the response for 0x10
    cycle(); cycle();
    lat_lo = 2; lat_hi = 2;
    cycle();
    PCSrc_E = 1; PCTarget_E = 32'h43; Flush_D = 1;
    cycle();
    PCSrc_E = 0; Flush_D = 0;
    lat_lo = 0; lat_hi = 0;
    chk("redir_wait_valid", {31'b0, valid_D}, 32'd0);
    for (int i = 0; i < 10 && (outst || have); i++) cycle();
    chk("redir_wait_req", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_wait_addr", imem_req_addr, 32'h40);
    chk("redir_wait_drop", {31'b0, valid_D}, 32'd0);

    // redirect while holding a buffered word
    Stall_D = 1;
    cycle(); cycle();
    PCSrc_E = 1; PCTarget_E = 32'h80; Flush_D = 1;
    cycle();
    PCSrc_E = 0; Flush_D = 0; Stall_D = 0;
    chk("redir_hold_req", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_hold_addr", imem_req_addr, 32'h80);
    chk("redir_hold_valid", {31'b0, valid_D}, 32'd0);
    cycle(); cycle();
    chk("redir_hold_pc", pc_D, 32'h80);
    chk("redir_hold_instr", instr_D, mem_word(32'h80));

    // redirect together with Stall_F
    Stall_F = 1;
    cycle(); cycle();
    PCSrc_E = 1; PCTarget_E = 32'h100; Flush_D = 1;
    cycle();
    PCSrc_E = 0; Flush_D = 0; Stall_F = 0;
    chk("redir_stallf_addr", imem_req_addr, 32'h100);
    chk("redir_stallf_req", {31'b0, imem_req_valid}, 32'd1);
    cycle(); cycle();
    chk("redir_stallf_pc", pc_D, 32'h100);
    chk("redir_stallf_valid", {31'b0, valid_D}, 32'd1);

    // flush and stall together
    Flush_D = 1; Stall_D = 1;
    cycle();
    Flush_D = 0; Stall_D = 0;
    chk("flush_stall_instr", instr_D, 32'd0);
    chk("flush_stall_valid", {31'b0, valid_D}, 32'd0);

    // reset while waiting on a response
    cycle();
    chk("pre_reset_pc", pc_D, 32'h104);
    Stall_D = 1; lat_lo = 3; lat_hi = 3;
    cycle();
    reset = 1;
    cycle();
    reset = 0; Stall_D = 0; lat_lo = 0; lat_hi = 0;
    chk("rst_wait_instr", instr_D, 32'd0);
    chk("rst_wait_pc", pc_D, 32'd0);
    chk("rst_wait_p4", pcplus4_D, 32'd0);
    chk("rst_wait_valid", {31'b0, valid_D}, 32'd0);
    chk("rst_wait_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_wait_addr", imem_req_addr, 32'd0);

    // PC+4 wrap at the top of the address space
    PCSrc_E = 1; PCTarget_E = 32'hFFFF_FFFE; Flush_D = 1;
    cycle();
    PCSrc_E = 0; Flush_D = 0;
    for (int i = 0; i < 10 && (outst || have); i++) cycle();
    chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    cycle(); cycle();
    chk("wrap_pc", pc_D, 32'hFFFF_FFFC);
    chk("wrap_p4", pcplus4_D, 32'h0);
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    // randomized traffic against the model
    rdy_pct = 70; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      Stall_F    = ($urandom_range(99, 0) < 15);
      Stall_D    = ($urandom_range(99, 0) < 15);
      PCSrc_E    = ($urandom_range(99, 0) < 5);
      PCTarget_E = $urandom();
      Flush_D    = PCSrc_E || ($urandom_range(99, 0) < 3);
      reset      = ($urandom_range(999, 0) < 3);
      cycle();
    end
    reset = 0; Stall_F = 0; Stall_D = 0; PCSrc_E = 0; Flush_D = 0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
